multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Main control unit for the multicycle RISC-V (RV32I subset: lw, sw, R-type, I-type ALU, beq, jal) core that shares one memory and one ALU across instruction phases. A Moore FSM sequences fetch, decode, execute, memory and writeback. A combinational ALU decoder and an immediate-select decoder complete it. The block sits beside the multicycle datapath and drives all of its enables and muxes; the top-level bench observes MemWrite, DataAdr and WriteData as before.

Parameters:
STATE_W, 4, state register width (11 states used)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  7  instruction opcode (Instr[6:0]) from IR
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
Zero  in  1  ALU zero flag
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address mux: 0 = PC, 1 = Result
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction/OldPC register enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
RegWrite  out  1  register file write enable
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
state_o  out  4  current state, for debug and bench

Behaviour:
- Reset: asynchronous, active-low. While reset=0: state=FETCH; PCWrite, IRWrite, RegWrite, MemWrite, illegal_op forced 0. Other outputs take their FETCH values.
- First rising edge after release performs the first fetch.
- Outputs are Moore decodes of state, with two exceptions:
  - PCWrite = PCUpdate | (Branch & Zero).
  - ALUControl also depends on op, funct3 and funct7b5.
- ImmSrc is a pure decode of op: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- Unlisted outputs are 0 in every state.
- States, with outputs -> next state:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precomputes branch target).
    - lw/sw -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> FETCH, with illegal_op=1.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 -> FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- Cycle counts: lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2.
- ALU decoder:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000: sub if op[5]&funct7b5, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - Other funct3: add (defined, never X).
- Illegal states (unused encodings) -> FETCH on the next edge.
- Reset asserted mid-instruction: state returns to FETCH immediately and write enables drop in the same cycle. No partial MemWrite or RegWrite completes.

Decomposition:
- Shared package riscv_pkg:
  - state encodings (FETCH = 0 ... JAL = 10)
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALUOp codes
  - ALUControl codes
  - ImmSrc codes
- One sub-module, alu_decoder: inputs ALUOp, op[5], funct3, funct7b5; output ALUControl. Purely combinational.
- The FSM and output decode stay in multicycle_controller.

Test Plan:
1. Release reset, op=0000011 (lw): state_o sequence 0,1,2,3,4,0. IRWrite=1 and PCWrite=1 only in cycle 1. RegWrite=1 only in MEMWB with ResultSrc=01.
2. op=0100011 (sw): sequence FETCH, DECODE, MEMADR, MEMWRITE. MemWrite=1 exactly one cycle with AdrSrc=1. ImmSrc=01 throughout.
3. op=0110011, funct3=000, funct7b5=1: ALUControl=001 in EXECR. Same with funct7b5=0 gives 000. funct3=111 gives 010, funct3=010 gives 101.
4. op=1100011 (beq): with Zero=1 in BEQ, PCWrite=1. With Zero=0, PCWrite=0. Total 3 cycles, back to FETCH.
5. op=1101111 (jal): JAL asserts PCWrite=1 with ALUSrcA=01 and ALUSrcB=10, then ALUWB asserts RegWrite=1. ImmSrc=11.
6. op=1111111: illegal_op pulses for 1 cycle in DECODE, then FETCH. Separately, drive reset=0 during MEMWRITE: MemWrite falls to 0 without a clock edge and state_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU operation classes, ALU control codes and immediate formats.
package riscv_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU operation class and the
// instruction's funct fields onto an ALU control code.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Decode ALU control; sub only for R-type with funct7[5] set (I-type addi never subtracts)
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback phases and drives every datapath enable/mux.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_t     state_r;
  logic       pc_update_s;
  logic       branch_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       mem_write_s;
  logic [1:0] alu_op_s;

  // State register; unused encodings fall back to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
    end else begin
      case (state_r)
        FETCH:  state_r <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state_r <= MEMADR;
            OP_R:         state_r <= EXECR;
            OP_I:         state_r <= EXECI;
            OP_BEQ:       state_r <= BEQ;
            OP_JAL:       state_r <= JAL;
            default:      state_r <= FETCH;
          endcase
        end
        MEMADR:   state_r <= (op == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  state_r <= MEMWB;
        MEMWB:    state_r <= FETCH;
        MEMWRITE: state_r <= FETCH;
        EXECR:    state_r <= ALUWB;
        EXECI:    state_r <= ALUWB;
        ALUWB:    state_r <= FETCH;
        BEQ:      state_r <= FETCH;
        JAL:      state_r <= ALUWB;
        default:  state_r <= FETCH;
      endcase
    end
  end

  // Moore output decode of the current state
  always_comb begin
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op_s    = ALUOP_ADD;
    case (state_r)
      FETCH: begin
        ir_write_s  = 1'b1;
        pc_update_s = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECR: begin
        ALUSrcA  = 2'b10;
        alu_op_s = ALUOP_FUNCT;
      end
      EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        alu_op_s = ALUOP_FUNCT;
      end
      ALUWB:    reg_write_s = 1'b1;
      BEQ: begin
        ALUSrcA  = 2'b10;
        alu_op_s = ALUOP_SUB;
        branch_s = 1'b1;
      end
      JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        pc_update_s = 1'b1;
      end
      default: begin
        pc_update_s = 1'b0;
      end
    endcase
  end

  // Immediate format follows the opcode alone
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  // Enables are gated by reset so an asserted reset kills writes without waiting for a clock
  assign PCWrite    = reset & (pc_update_s | (branch_s & Zero));
  assign IRWrite    = reset & ir_write_s;
  assign RegWrite   = reset & reg_write_s;
  assign MemWrite   = reset & mem_write_s;
  assign illegal_op = reset & (state_r == DECODE) & ~op_supported(op);
  assign state_o    = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instructions, reset
// cases and randomized instruction streams against a per-instruction cycle model.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       regw;
    logic       ill;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  int vectors;
  int miscompares;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  function automatic bit legal(input logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
  endfunction

  function automatic int cycles_of(input logic [6:0] o);
    if (o == LW) return 5;
    else if (o == SW || o == RT || o == IT || o == JL) return 4;
    else if (o == BQ) return 3;
    else return 2;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    else if (o == BQ) return 2'b10;
    else if (o == JL) return 2'b11;
    else return 2'b00;
  endfunction

  function automatic logic [2:0] arith_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o[5] && f7) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) return 3'b101;
    else if (f3 == 3'b110) return 3'b011;
    else if (f3 == 3'b111) return 3'b010;
    else return 3'b000;
  endfunction

  // Expected controls for cycle c (1-based) of instruction o, or while reset is held
  function automatic obs_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input int c, input bit in_reset);
    obs_t e;
    e = '0;
    e.imm = imm_of(o);
    if (in_reset) begin
      e.sb = 2'b10; e.rs = 2'b10;
    end else if (c == 1) begin
      e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'b10; e.rs = 2'b10;
    end else if (c == 2) begin
      e.st = 4'd1; e.sa = 2'b01; e.sb = 2'b01; e.ill = !legal(o);
    end else if ((o == LW || o == SW) && c == 3) begin
      e.st = 4'd2; e.sa = 2'b10; e.sb = 2'b01;
    end else if (o == LW && c == 4) begin
      e.st = 4'd3; e.adr = 1'b1;
    end else if (o == LW && c == 5) begin
      e.st = 4'd4; e.rs = 2'b01; e.regw = 1'b1;
    end else if (o == SW && c == 4) begin
      e.st = 4'd5; e.adr = 1'b1; e.memw = 1'b1;
    end else if ((o == RT || o == IT) && c == 3) begin
      e.st = (o == RT) ? 4'd6 : 4'd7; e.sa = 2'b10;
      e.sb = (o == RT) ? 2'b00 : 2'b01; e.alu = arith_of(o, f3, f7);
    end else if (o == BQ && c == 3) begin
      e.st = 4'd9; e.sa = 2'b10; e.alu = 3'b001; e.pcw = z;
    end else if (o == JL && c == 3) begin
      e.st = 4'd10; e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
    end else begin
      e.st = 4'd8; e.regw = 1'b1;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    return '{st: state_o, pcw: PCWrite, adr: AdrSrc, memw: MemWrite, irw: IRWrite,
             rs: ResultSrc, sa: ALUSrcA, sb: ALUSrcB, alu: ALUControl, imm: ImmSrc,
             regw: RegWrite, ill: illegal_op};
  endfunction

  task automatic check(input string tag, input int c, input obs_t exp);
    obs_t got;
    got = sample();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cyc %0d: observed %h expected %h", tag, c, got, exp);
    end
  endtask

  // Run one instruction from FETCH; zmode 0/1 fixes Zero, 2 randomizes it; abort_c>0 asserts reset in that cycle
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode, input int abort_c);
    int n;
    n = cycles_of(o);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int c = 1; c <= n; c++) begin
      Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      check(tag, c, model(o, f3, f7, Zero, c, 1'b0));
      if (c == abort_c) begin
        #2 reset = 1'b0;
        #1 check({tag, "_rst"}, c, model(o, f3, f7, Zero, c, 1'b1));
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [6:0] rop;
    int k;
    vectors = 0;
    miscompares = 0;
    reset = 1'b0; op = SW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("reset", 0, model(SW, 3'b000, 1'b0, 1'b1, 0, 1'b1));
    @(negedge clk);
    reset = 1'b1;

    run_instr("lw",       LW, 3'b010, 1'b0, 2, 0);
    run_instr("sw",       SW, 3'b010, 1'b0, 2, 0);
    run_instr("add",      RT, 3'b000, 1'b0, 0, 0);
    run_instr("sub",      RT, 3'b000, 1'b1, 0, 0);
    run_instr("and",      RT, 3'b111, 1'b0, 0, 0);
    run_instr("slt",      RT, 3'b010, 1'b0, 0, 0);
    run_instr("or",       RT, 3'b110, 1'b1, 0, 0);
    run_instr("addi_f7",  IT, 3'b000, 1'b1, 0, 0);
    run_instr("r_f3_001", RT, 3'b001, 1'b1, 0, 0);
    run_instr("beq_taken", BQ, 3'b000, 1'b0, 1, 0);
    run_instr("beq_not",  BQ, 3'b000, 1'b0, 0, 0);
    run_instr("jal",      JL, 3'b000, 1'b0, 0, 0);
    run_instr("illegal",  7'b1111111, 3'b000, 1'b0, 0, 0);
    run_instr("sw_abort", SW, 3'b000, 1'b0, 0, 4);
    run_instr("lw_abort", LW, 3'b000, 1'b0, 0, 5);
    run_instr("lw_after", LW, 3'b000, 1'b0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = IT;
        4: rop = BQ;
        5: rop = JL;
        default: begin
          rop = 7'($urandom);
          while (legal(rop)) rop = 7'($urandom);
        end
      endcase
      run_instr("rand", rop, 3'($urandom), 1'($urandom), 2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
